float_addition_core: RTL and testbench
======================================

// Module: float_addition_core
// PURPOSE
//  IEEE-754 single-precision adder/subtractor computing A+B (op=0) or A-B (op=1).
//  Multi-cycle, iterative: a control FSM sequences a datapath through exponent compare, align, add, normalize and round.
//  Standalone arithmetic block. One operation runs automatically after each reset release.
//  The result is held until the next reset.
// PARAMETERS
//  none (format fixed: 1 sign, 8 exponent (bias 127), 23 fraction)
// PORTS
//  clk     in   1   single clock, rising edge
//  reset   in   1   synchronous, active-low reset
//  op      in   1   0 = add, 1 = subtract (B sign inverted)
//  A       in   32  operand A, IEEE-754 single
//  B       in   32  operand B, IEEE-754 single
//  result  out  32  rounded sum/difference, valid while done=1
//  done    out  1   high from the DONE state until reset
// BEHAVIOUR
//  Reset (reset=0 at a clk edge): state=LOAD, result=32'h0, done=0, all internal registers cleared.
//  FSM, one state per clock unless noted:
//   LOAD: register A, B and op.
//     - Effective sign of B = B[31]^op.
//     - Mantissas get the hidden 1; exponent 0 (denormal or zero) is flushed to zero.
//   ALIGN: small ALU computes d = eA-eB.
//     - Swap so the larger magnitude is operand X.
//     - Shift Y right by d; bits shifted out go into G/R/S (sticky ORs the rest).
//     - d>=27 makes Y all sticky.
//   ADD: big ALU on a 28-bit mantissa (carry, hidden, 23 fraction, G, R, S).
//     - Adds if the effective signs are equal, else computes X-Y.
//     - Result sign = sign of X.
//   NORM: if carry, shift right 1 (S keeps ORed) and increment exponent (1 cycle).
//     - Else, while hidden bit=0, shift left 1 and decrement exponent, one bit per cycle.
//     - A zero mantissa skips NORM and gives +0.
//   ROUND: round-to-nearest-even on G, R, S.
//     - Mantissa overflow from rounding: shift right and increment exponent (same cycle).
//   DONE: drive result, done=1; stay until reset.
//  Latency: reset release to done = 5 + k cycles, k = normalization shifts (0..26).
//  Special cases, resolved in LOAD and jumping straight to DONE:
//   - any NaN -> 32'h7FC00000
//   - +inf + -inf (effective) -> 32'h7FC00000
//   - inf op finite -> that inf with its effective sign
//   - both operands zero -> +0, except (-0)+(-0) -> -0
//  Exponent overflow (>=255) -> +/-inf. Exponent underflow (<=0) -> +/-0 (flush to zero).
//  Inputs changed mid-operation are ignored; they are sampled only in LOAD.
//  Reset mid-operation aborts and restarts from LOAD.
// CONFIGURATION
//  FP_FLAGS_EN defined:
//   - Adds outputs ovf, unf, inx (1 bit each), cleared on reset, valid with done.
//   - ovf: overflow to inf.
//   - unf: result flushed to zero.
//   - inx: G|R|S nonzero before rounding.
//  FP_FLAGS_EN undefined: these ports and their logic do not exist; the result is identical.
// TESTING
//  A=4000000F B=C0000007 op=0 -> result=36000000 (20 NORM shifts), done=1
//  A=4000000F B=C0000007 op=1 -> result=4080000B (carry right-shift)
//  A=3F800000 B=3F800000 op=0 -> 40000000
//  A=3FC00000 B=3F000000 op=1 -> 3F800000
//  A=3F800000 B=33800000 op=0 -> 3F800000 (tie to even)
//  A=3F800000 B=33C00000 op=0 -> 3F800001
//  A=7F7FFFFF B=7F7FFFFF op=0 -> 7F800000 (ovf=1 if FP_FLAGS_EN)
//  A=7F800000 B=7F800000 op=1 -> 7FC00000
//  Assert reset mid-NORM -> done=0, result=0 next edge; rerun gives the same result.

Source files
------------

// File: rtl/float_addition_core.sv
// Iterative IEEE-754 single-precision adder/subtractor: LOAD, ALIGN, ADD, NORM, ROUND, DONE.
// Optional status outputs ovf/unf/inx exist only when FP_FLAGS_EN is defined.
module float_addition_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic        done
`ifdef FP_FLAGS_EN
  ,
  output logic        ovf,
  output logic        unf,
  output logic        inx
`endif
);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state_r, state_s;

  logic              sign_a_r, sign_b_r;
  logic [7:0]        exp_a_r, exp_b_r;
  logic [23:0]       mant_a_r, mant_b_r;
  logic              sign_r, sub_r;
  logic signed [9:0] exp_r;
  logic [27:0]       x_mant_r, y_mant_r, mant_r;
  logic [31:0]       result_r;
  logic              done_r;

  logic              eff_sign_b_s;
  logic              a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic              special_s;
  logic [31:0]       special_res_s;

  // Special-operand detection on the live inputs, consumed only in LOAD
  always_comb begin
    eff_sign_b_s  = B[31] ^ op;
    a_nan_s       = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
    b_nan_s       = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
    a_inf_s       = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
    b_inf_s       = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
    a_zero_s      = (A[30:23] == 8'h00);
    b_zero_s      = (B[30:23] == 8'h00);
    special_s     = 1'b1;
    special_res_s = 32'h7FC0_0000;
    if (a_nan_s || b_nan_s) begin
      special_res_s = 32'h7FC0_0000;
    end else if (a_inf_s && b_inf_s && (A[31] != eff_sign_b_s)) begin
      special_res_s = 32'h7FC0_0000;
    end else if (a_inf_s) begin
      special_res_s = {A[31], 8'hFF, 23'd0};
    end else if (b_inf_s) begin
      special_res_s = {eff_sign_b_s, 8'hFF, 23'd0};
    end else if (a_zero_s && b_zero_s) begin
      special_res_s = {A[31] & eff_sign_b_s, 31'd0};
    end else begin
      special_s     = 1'b0;
      special_res_s = 32'd0;
    end
  end

  logic        a_ge_b_s, sign_x_s;
  logic [7:0]  exp_x_s, exp_y_s, diff_s;
  logic [27:0] x_ext_s, y_ext_s, y_shift_s;

  // Swap so X has the larger magnitude, then align Y with guard/round/sticky
  always_comb begin
    a_ge_b_s = ({exp_a_r, mant_a_r} >= {exp_b_r, mant_b_r});
    if (a_ge_b_s) begin
      sign_x_s = sign_a_r;
      exp_x_s  = exp_a_r;
      exp_y_s  = exp_b_r;
      x_ext_s  = {1'b0, mant_a_r, 3'b000};
      y_ext_s  = {1'b0, mant_b_r, 3'b000};
    end else begin
      sign_x_s = sign_b_r;
      exp_x_s  = exp_b_r;
      exp_y_s  = exp_a_r;
      x_ext_s  = {1'b0, mant_b_r, 3'b000};
      y_ext_s  = {1'b0, mant_a_r, 3'b000};
    end
    diff_s = exp_x_s - exp_y_s;
    if (diff_s >= 8'd27) begin
      y_shift_s = {27'd0, |y_ext_s};
    end else begin
      y_shift_s = (y_ext_s >> diff_s) |
                  {27'd0, |(y_ext_s & ((28'd1 << diff_s) - 28'd1))};
    end
  end

  logic [27:0] sum_s;

  // Mantissa adder/subtractor; X >= Y so the difference never goes negative
  always_comb begin
    if (sub_r) begin
      sum_s = x_mant_r - y_mant_r;
    end else begin
      sum_s = x_mant_r + y_mant_r;
    end
  end

  logic              round_up_s, ovf_s, unf_s;
  logic [24:0]       rounded_s;
  logic signed [9:0] exp_rnd_s;
  logic [22:0]       frac_rnd_s;
  logic [31:0]       round_res_s;

  // Round-to-nearest-even, renormalise a rounding carry, then clamp the exponent
  always_comb begin
    round_up_s = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
    rounded_s  = {1'b0, mant_r[26:3]} + {24'd0, round_up_s};
    if (rounded_s[24]) begin
      exp_rnd_s  = exp_r + 10'sd1;
      frac_rnd_s = rounded_s[23:1];
    end else begin
      exp_rnd_s  = exp_r;
      frac_rnd_s = rounded_s[22:0];
    end
    ovf_s = (exp_rnd_s >= 10'sd255);
    unf_s = (exp_rnd_s <= 10'sd0);
    if (ovf_s) begin
      round_res_s = {sign_r, 8'hFF, 23'd0};
    end else if (unf_s) begin
      round_res_s = {sign_r, 31'd0};
    end else begin
      round_res_s = {sign_r, exp_rnd_s[7:0], frac_rnd_s};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; NORM holds until the hidden bit (or carry) is set
  always_comb begin
    state_s = state_r;
    case (state_r)
      LOAD: begin
        if (special_s) begin
          state_s = DONE;
        end else begin
          state_s = ALIGN;
        end
      end
      ALIGN: state_s = ADD;
      ADD: begin
        if (sum_s == 28'd0) begin
          state_s = DONE;
        end else begin
          state_s = NORM;
        end
      end
      NORM: begin
        if (mant_r[27] || mant_r[26]) begin
          state_s = ROUND;
        end else begin
          state_s = NORM;
        end
      end
      ROUND:   state_s = DONE;
      DONE:    state_s = DONE;
      default: state_s = LOAD;
    endcase
  end

  // Datapath registers and registered outputs, advanced per state
  always_ff @(posedge clk) begin
    if (!reset) begin
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      exp_a_r  <= 8'd0;
      exp_b_r  <= 8'd0;
      mant_a_r <= 24'd0;
      mant_b_r <= 24'd0;
      sign_r   <= 1'b0;
      sub_r    <= 1'b0;
      exp_r    <= 10'sd0;
      x_mant_r <= 28'd0;
      y_mant_r <= 28'd0;
      mant_r   <= 28'd0;
      result_r <= 32'd0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          sign_a_r <= A[31];
          sign_b_r <= eff_sign_b_s;
          exp_a_r  <= A[30:23];
          exp_b_r  <= B[30:23];
          mant_a_r <= a_zero_s ? 24'd0 : {1'b1, A[22:0]};
          mant_b_r <= b_zero_s ? 24'd0 : {1'b1, B[22:0]};
          if (special_s) begin
            result_r <= special_res_s;
            done_r   <= 1'b1;
          end
        end
        ALIGN: begin
          sign_r   <= sign_x_s;
          sub_r    <= sign_a_r ^ sign_b_r;
          exp_r    <= $signed({2'b00, exp_x_s});
          x_mant_r <= x_ext_s;
          y_mant_r <= y_shift_s;
        end
        ADD: begin
          mant_r <= sum_s;
          if (sum_s == 28'd0) begin
            result_r <= 32'd0;
            done_r   <= 1'b1;
          end
        end
        NORM: begin
          if (mant_r[27]) begin
            mant_r <= {1'b0, mant_r[27:2], mant_r[1] | mant_r[0]};
            exp_r  <= exp_r + 10'sd1;
          end else if (!mant_r[26]) begin
            mant_r <= {mant_r[26:0], 1'b0};
            exp_r  <= exp_r - 10'sd1;
          end
        end
        ROUND: begin
          result_r <= round_res_s;
          done_r   <= 1'b1;
        end
        DONE: begin
          done_r <= 1'b1;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign result = result_r;
  assign done   = done_r;

`ifdef FP_FLAGS_EN
  logic ovf_r, unf_r, inx_r;

  // Status flags, captured in the same cycle as the rounded result
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
      inx_r <= 1'b0;
    end else if (state_r == ROUND) begin
      ovf_r <= ovf_s;
      unf_r <= unf_s;
      inx_r <= |mant_r[2:0];
    end else begin
      ovf_r <= ovf_r;
      unf_r <= unf_r;
      inx_r <= inx_r;
    end
  end

  assign ovf = ovf_r;
  assign unf = unf_r;
  assign inx = inx_r;
`endif

endmodule

// File: tb/tb_float_addition_core.sv
// Directed, table-driven bench for float_addition_core: results, latency, reset and hold behaviour.
module tb_float_addition_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        op;
  logic [31:0] A, B;
  logic [31:0] result;
  logic        done;
`ifdef FP_FLAGS_EN
  logic        ovf, unf, inx;
`endif

  int checks = 0;
  int errors = 0;

  float_addition_core dut (
    .clk    (clk),
    .reset  (reset),
    .op     (op),
    .A      (A),
    .B      (B),
    .result (result),
    .done   (done)
`ifdef FP_FLAGS_EN
    ,
    .ovf    (ovf),
    .unf    (unf),
    .inx    (inx)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs [0:18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive operands, hold reset low for one edge, release at the following negedge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic o);
    @(negedge clk);
    A     = a;
    B     = b;
    op    = o;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 60) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    vecs[0]  = '{32'h4000000F, 32'hC0000007, 1'b0, 32'h36000000, 25};
    vecs[1]  = '{32'h4000000F, 32'hC0000007, 1'b1, 32'h4080000B, 5};
    vecs[2]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5};
    vecs[3]  = '{32'h3FC00000, 32'h3F000000, 1'b1, 32'h3F800000, 5};
    vecs[4]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 5};
    vecs[5]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 5};
    vecs[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5};
    vecs[7]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1};
    vecs[8]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 1};
    vecs[9]  = '{32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 1};
    vecs[10] = '{32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 1};
    vecs[11] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1};
    vecs[12] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1};
    vecs[13] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3};
    vecs[14] = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 28};
    vecs[15] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 28};
    vecs[16] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 6};
    vecs[17] = '{32'h3F800000, 32'h30000000, 1'b0, 32'h3F800000, 5};
    vecs[18] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 1};

    reset = 1'b0;
    op    = 1'b0;
    A     = 32'd0;
    B     = 32'd0;

    for (int i = 0; i < 19; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].op);
      check($sformatf("v%0d_rst_done", i), {31'd0, done}, 32'd0);
      check($sformatf("v%0d_rst_result", i), result, 32'd0);
      wait_done(cyc);
      check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].lat));
    end

    // Result and done hold after completion
    repeat (5) @(negedge clk);
    check("hold_done", {31'd0, done}, 32'd1);
    check("hold_result", result, 32'h00000000);

    // Reset in the middle of a long normalisation aborts, rerun gives the same answer
    start_op(32'h4000000F, 32'hC0000007, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("midnorm_busy", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midnorm_rst_done", {31'd0, done}, 32'd0);
    check("midnorm_rst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_done(cyc);
    check("rerun_result", result, 32'h36000000);
    check("rerun_latency", 32'(cyc), 32'd25);

    // Inputs changed after LOAD are ignored
    start_op(32'h3F800000, 32'h3F800000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    A  = 32'h7FC00000;
    B  = 32'hC0400000;
    op = 1'b1;
    wait_done(cyc);
    check("late_in_result", result, 32'h40000000);
    check("late_in_latency", 32'(cyc), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
